// File: rtl/mem_wb_align_pkg.sv
// Shared widths and encodings for the MEM->WB alignment stage.
// Load-op codes match the decoder's load-kind field.
package mem_wb_align_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'd0,
      LOAD_LB   = 3'd1,
      LOAD_LBU  = 3'd2,
      LOAD_LH   = 3'd3,
      LOAD_LHU  = 3'd4,
      LOAD_LW   = 3'd5,
      LOAD_LWL  = 3'd6,
      LOAD_LWR  = 3'd7
   } load_op_e;

   typedef enum logic {
      HOLD_LIVE = 1'b0,
      HOLD_HELD = 1'b1
   } hold_state_e;

endpackage

// File: rtl/mem_wb_align_load_align.sv
// Combinational load extraction: byte/half select with extension and
// the LWL/LWR partial merges against the old rt value.
module load_align
   import mem_wb_align_pkg::*;
(
   input  load_op_e           op,
   input  logic [1:0]         lo,
   input  logic [REG_BUS-1:0] w,
   input  logic [REG_BUS-1:0] r,
   output logic [REG_BUS-1:0] data
);

   function automatic logic [REG_BUS-1:0] ext8(input logic [7:0] b, input logic sgn);
      logic signed [7:0]         sb;
      logic signed [REG_BUS-1:0] sw;
      sb = b;
      sw = sb;
      ext8 = sgn ? sw : {24'b0, b};
   endfunction

   function automatic logic [REG_BUS-1:0] ext16(input logic [15:0] h, input logic sgn);
      logic signed [15:0]        sh;
      logic signed [REG_BUS-1:0] sw;
      sh = h;
      sw = sh;
      ext16 = sgn ? sw : {16'b0, h};
   endfunction

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lanes are little-endian; lo[0] is ignored for halves since misaligned halves trap upstream.
   assign byte_sel = w[{lo, 3'b000} +: 8];
   assign half_sel = w[{lo[1], 4'b0000} +: 16];

   always_comb begin
      data = '0;
      case (op)
         LOAD_LB:  data = ext8(byte_sel, 1'b1);
         LOAD_LBU: data = ext8(byte_sel, 1'b0);
         LOAD_LH:  data = ext16(half_sel, 1'b1);
         LOAD_LHU: data = ext16(half_sel, 1'b0);
         LOAD_LW:  data = w;
         LOAD_LWL: begin
            case (lo)
               2'd0:    data = {w[7:0],  r[23:0]};
               2'd1:    data = {w[15:0], r[15:0]};
               2'd2:    data = {w[23:0], r[7:0]};
               default: data = w;
            endcase
         end
         LOAD_LWR: begin
            case (lo)
               2'd0:    data = w;
               2'd1:    data = {r[31:24], w[31:8]};
               2'd2:    data = {r[31:16], w[31:16]};
               default: data = {r[31:8],  w[31:24]};
            endcase
         end
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/mem_wb_align.sv
// MEM->WB pipeline register with load-data merge and a hold register
// that keeps the memory word stable while WB is stalled.
module mem_wb_align
   import mem_wb_align_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_we,
   input  logic [REG_ADDR_BUS-1:0] mem_waddr,
   input  logic [REG_BUS-1:0]      mem_wdata,
   input  logic [2:0]              mem_load_op,
   input  logic [1:0]              mem_addr_lo,
   input  logic [REG_BUS-1:0]      mem_rt_data,
   input  logic [REG_BUS-1:0]      dmem_rdata,
   input  logic                    stall_mem,
   input  logic                    stall_wb,
   input  logic                    flush,
   output logic                    wb_we,
   output logic [REG_ADDR_BUS-1:0] wb_waddr,
   output logic [REG_BUS-1:0]      wb_wdata,
   output logic                    wb_is_load
);

   logic                    we_p0;
   logic [REG_ADDR_BUS-1:0] waddr_p0;
   logic [REG_BUS-1:0]      wdata_p0;
   load_op_e                op_p0;
   logic [1:0]              lo_p0;
   logic [REG_BUS-1:0]      rt_p0;

   hold_state_e        state_q;
   hold_state_e        state_d;
   logic               hold_load;
   logic               hold_valid;
   logic [REG_BUS-1:0] hold_data;

   logic [REG_BUS-1:0] src_word;
   logic [REG_BUS-1:0] load_word;

   // ---- MEM -> WB stage register ----
   always_ff @(posedge clk) begin
      if (rst || flush || (!stall_wb && stall_mem)) begin
         we_p0    <= 1'b0;
         waddr_p0 <= '0;
         wdata_p0 <= '0;
         op_p0    <= LOAD_NONE;
         lo_p0    <= '0;
         rt_p0    <= '0;
      end else if (!stall_wb) begin
         we_p0    <= mem_we;
         waddr_p0 <= mem_waddr;
         wdata_p0 <= mem_wdata;
         op_p0    <= load_op_e'(mem_load_op);
         lo_p0    <= mem_addr_lo;
         rt_p0    <= mem_rt_data;
      end
   end

   // Hold FSM: capture the read word on the first stalled edge only, since
   // the memory stops presenting it once the pipeline has moved on.
   always_comb begin
      state_d   = state_q;
      hold_load = 1'b0;
      if (flush) begin
         state_d = HOLD_LIVE;
      end else begin
         case (state_q)
            HOLD_LIVE: begin
               if (stall_wb && (op_p0 != LOAD_NONE)) begin
                  state_d   = HOLD_HELD;
                  hold_load = 1'b1;
               end
            end
            HOLD_HELD: begin
               if (!stall_wb) state_d = HOLD_LIVE;
            end
            default: state_d = HOLD_LIVE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HOLD_LIVE;
         hold_data <= '0;
      end else begin
         state_q <= state_d;
         if (hold_load) hold_data <= dmem_rdata;
      end
   end

   assign hold_valid = (state_q == HOLD_HELD);
   assign src_word   = hold_valid ? hold_data : dmem_rdata;

   load_align u_load_align (
      .op   (op_p0),
      .lo   (lo_p0),
      .w    (src_word),
      .r    (rt_p0),
      .data (load_word)
   );

   // ---- WB outputs ----
   assign wb_we      = we_p0 && (waddr_p0 != '0);
   assign wb_waddr   = waddr_p0;
   assign wb_is_load = (op_p0 != LOAD_NONE);
   assign wb_wdata   = wb_is_load ? load_word : wdata_p0;

endmodule

// File: tb/tb_mem_wb_align.sv
// Self-checking bench for mem_wb_align: directed cases then randomized
// traffic against a shift/mask reference of the load rules.
module tb_mem_wb_align;

   logic        clk;
   logic        rst;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_load_op;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_rt_data;
   logic [31:0] dmem_rdata;
   logic        stall_mem;
   logic        stall_wb;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        wb_is_load;

   int checks;
   int failures;

   mem_wb_align dut (
      .clk         (clk),
      .rst         (rst),
      .mem_we      (mem_we),
      .mem_waddr   (mem_waddr),
      .mem_wdata   (mem_wdata),
      .mem_load_op (mem_load_op),
      .mem_addr_lo (mem_addr_lo),
      .mem_rt_data (mem_rt_data),
      .dmem_rdata  (dmem_rdata),
      .stall_mem   (stall_mem),
      .stall_wb    (stall_wb),
      .flush       (flush),
      .wb_we       (wb_we),
      .wb_waddr    (wb_waddr),
      .wb_wdata    (wb_wdata),
      .wb_is_load  (wb_is_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [2:0]  op;
      logic [1:0]  lo;
      logic [31:0] rt;
   } ent_t;

   ent_t        m_ent;
   logic        m_held;
   logic [31:0] m_hword;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] w, input logic [31:0] r);
      int          sh;
      logic [31:0] v;
      logic [31:0] m;
      v = 32'h0;
      case (op)
         3'd1, 3'd2: begin
            sh = 8 * int'(lo);
            v  = (w >> sh) & 32'hFF;
            if (op == 3'd1 && v[7]) v = v | 32'hFFFFFF00;
         end
         3'd3, 3'd4: begin
            sh = 16 * int'(lo[1]);
            v  = (w >> sh) & 32'hFFFF;
            if (op == 3'd3 && v[15]) v = v | 32'hFFFF0000;
         end
         3'd5: v = w;
         3'd6: begin
            sh = 8 * (3 - int'(lo));
            m  = (sh == 0) ? 32'h0 : (32'hFFFFFFFF >> (32 - sh));
            v  = (w << sh) | (r & m);
         end
         3'd7: begin
            sh = 8 * int'(lo);
            m  = 32'hFFFFFFFF >> sh;
            v  = (w >> sh) | (r & ~m);
         end
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic check_model();
      logic [31:0] exp_data;
      exp_data = (m_ent.op == 3'd0) ? m_ent.wdata
               : ref_align(m_ent.op, m_ent.lo, m_held ? m_hword : dmem_rdata, m_ent.rt);
      chk("wb_we",      {31'b0, wb_we},      {31'b0, m_ent.we && (m_ent.waddr != 5'd0)});
      chk("wb_waddr",   {27'b0, wb_waddr},   {27'b0, m_ent.waddr});
      chk("wb_is_load", {31'b0, wb_is_load}, {31'b0, m_ent.op != 3'd0});
      chk("wb_wdata",   wb_wdata,            exp_data);
      chk("hold_valid", {31'b0, dut.hold_valid}, {31'b0, m_held});
   endtask

   // Apply the currently driven inputs for one clock, then present rn as the new read word.
   task automatic cycle(input logic [31:0] rn);
      ent_t        n_ent;
      logic        n_held;
      logic [31:0] n_hword;
      ent_t        bubble;
      bubble  = '0;
      n_ent   = m_ent;
      n_held  = m_held;
      n_hword = m_hword;
      if (rst) begin
         n_ent = bubble; n_held = 1'b0; n_hword = 32'h0;
      end else begin
         if (flush)                                    n_held = 1'b0;
         else if (!m_held && stall_wb && m_ent.op != 0) begin n_held = 1'b1; n_hword = dmem_rdata; end
         else if (m_held && !stall_wb)                 n_held = 1'b0;
         if (flush)          n_ent = bubble;
         else if (stall_wb)  n_ent = m_ent;
         else if (stall_mem) n_ent = bubble;
         else n_ent = '{we: mem_we, waddr: mem_waddr, wdata: mem_wdata,
                        op: mem_load_op, lo: mem_addr_lo, rt: mem_rt_data};
      end
      @(posedge clk);
      #1;
      m_ent = n_ent; m_held = n_held; m_hword = n_hword;
      dmem_rdata = rn;
      #1;
      check_model();
   endtask

   task automatic set_mem(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rt);
      mem_we = we; mem_waddr = wa; mem_wdata = wd;
      mem_load_op = op; mem_addr_lo = lo; mem_rt_data = rt;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      checks = 0; failures = 0;
      m_ent = '0; m_held = 1'b0; m_hword = 32'h0;
      rst = 1'b1; flush = 1'b0; stall_wb = 1'b0; stall_mem = 1'b0;
      dmem_rdata = 32'h0;
      set_mem(1'b1, 5'd3, 32'hFFFFFFFF, 3'd0, 2'd0, 32'h0);

      cycle(32'h0);
      chk("rst_we", {31'b0, wb_we}, 32'h0);
      chk("rst_wdata", wb_wdata, 32'h0);
      rst = 1'b0;

      set_mem(1'b1, 5'd5, 32'h12345678, 3'd0, 2'd0, 32'h0);
      cycle(32'h0);
      chk("alu_we", {31'b0, wb_we}, 32'h1);
      chk("alu_waddr", {27'b0, wb_waddr}, 32'd5);
      chk("alu_wdata", wb_wdata, 32'h12345678);

      set_mem(1'b1, 5'd3, 32'h0, 3'd1, 2'd3, 32'h0);
      cycle(32'h80FF7F01);
      chk("lb_lo3", wb_wdata, 32'hFFFFFF80);
      set_mem(1'b1, 5'd3, 32'h0, 3'd2, 2'd3, 32'h0);
      cycle(32'h80FF7F01);
      chk("lbu_lo3", wb_wdata, 32'h00000080);
      set_mem(1'b1, 5'd3, 32'h0, 3'd3, 2'd2, 32'h0);
      cycle(32'h80FF7F01);
      chk("lh_lo2", wb_wdata, 32'hFFFF80FF);

      set_mem(1'b1, 5'd4, 32'h0, 3'd6, 2'd1, 32'h11223344);
      cycle(32'hAABBCCDD);
      chk("lwl_lo1", wb_wdata, 32'hCCDD3344);
      set_mem(1'b1, 5'd4, 32'h0, 3'd7, 2'd1, 32'h11223344);
      cycle(32'hAABBCCDD);
      chk("lwr_lo1", wb_wdata, 32'h11AABBCC);

      set_mem(1'b1, 5'd7, 32'h0, 3'd5, 2'd0, 32'h0);
      cycle(32'hDEADBEEF);
      chk("lw_wdata", wb_wdata, 32'hDEADBEEF);
      set_mem(1'b1, 5'd9, 32'h00000055, 3'd0, 2'd0, 32'h0);
      stall_wb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(32'h0);
         chk("lw_stall_wdata", wb_wdata, 32'hDEADBEEF);
         chk("lw_stall_we", {31'b0, wb_we}, 32'h1);
      end
      stall_wb = 1'b0;
      cycle(32'h0);
      chk("post_stall_waddr", {27'b0, wb_waddr}, 32'd9);
      chk("post_stall_wdata", wb_wdata, 32'h00000055);

      set_mem(1'b1, 5'd0, 32'hCAFEF00D, 3'd0, 2'd0, 32'h0);
      cycle(32'h0);
      chk("r0_we", {31'b0, wb_we}, 32'h0);

      set_mem(1'b1, 5'd12, 32'h0, 3'd5, 2'd0, 32'h0);
      cycle(32'h01020304);
      stall_mem = 1'b1;
      cycle(32'h0);
      chk("stall_mem_bubble", {31'b0, wb_we}, 32'h0);
      stall_mem = 1'b0;

      set_mem(1'b1, 5'd12, 32'h0, 3'd5, 2'd0, 32'h0);
      cycle(32'h01020304);
      flush = 1'b1; stall_wb = 1'b1;
      cycle(32'h0);
      chk("flush_stall_we", {31'b0, wb_we}, 32'h0);
      chk("flush_stall_hold", {31'b0, dut.hold_valid}, 32'h0);
      flush = 1'b0; stall_wb = 1'b0;

      set_mem(1'b1, 5'd13, 32'h0, 3'd5, 2'd0, 32'h0);
      cycle(32'h0BADF00D);
      stall_wb = 1'b1;
      cycle(32'h0);
      chk("held_wdata", wb_wdata, 32'h0BADF00D);
      rst = 1'b1;
      cycle(32'h0);
      chk("rst_held_we", {31'b0, wb_we}, 32'h0);
      chk("rst_held_wdata", wb_wdata, 32'h0);
      chk("rst_held_hold", {31'b0, dut.hold_valid}, 32'h0);
      rst = 1'b0; stall_wb = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(63) == 0);
         flush     = ($urandom_range(15) == 0);
         stall_wb  = ($urandom_range(3) == 0);
         stall_mem = ($urandom_range(7) == 0);
         set_mem(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
         cycle($urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_align.md
# mem_wb_align

Pipeline register between the MEM stage and the register-file write port. Captures the MEM-stage result each cycle and drives the write-enable, write-address and write-data of the general-purpose register file one cycle later. For loads it merges the synchronous data-memory read word into the final write value, including byte/half extraction and LWL/LWR partial merges. It also handles stall, flush and bubble insertion. While WB is stalled it latches the memory word so the write value stays stable.

## Interface
- No parameters. Widths come from the shared defines: `RegBus` = 32, `RegAddrBus` = 5.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (`RstEnable` = 1)
- mem_we  in  1  MEM-stage register write enable
- mem_waddr  in  5  destination register
- mem_wdata  in  32  ALU result (used when not a load)
- mem_load_op  in  3  load kind (see Operation)
- mem_addr_lo  in  2  byte offset of the load address
- mem_rt_data  in  32  old rt value, used for the LWL/LWR merge
- dmem_rdata  in  32  data-memory read word; valid the cycle after the address is presented in MEM
- stall_mem  in  1  MEM stage stalled
- stall_wb  in  1  WB stage stalled
- flush  in  1  kill the instruction entering WB
- wb_we  out  1  register-file write enable
- wb_waddr  out  5  register-file write address
- wb_wdata  out  32  register-file write data (combinational from stage register, dmem_rdata or hold register)
- wb_is_load  out  1  WB holds a load; hazard unit uses it for forwarding

## Operation
- Load codes (`define.v`): NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7. Codes 7+1 do not exist; any unlisted value is treated as NONE.
- Byte lanes are little-endian: offset 0 is bits 7:0.
- Stage register update, in priority order:
  1. rst: all fields cleared.
  2. flush: insert a bubble (we=0, op=NONE, waddr=0, data=0).
  3. stall_wb: hold all fields.
  4. stall_mem: insert a bubble.
  5. Otherwise: capture the mem_* inputs.
- Load data selection:
  - Source word W = hold_data if hold_valid, else dmem_rdata.
  - LB/LBU: byte W[8*lo+7 : 8*lo], sign-/zero-extended.
  - LH/LHU: half selected by lo[1], sign-/zero-extended; lo[0] is ignored because misalignment traps upstream.
  - LW: W.
  - LWL, where R is the stored rt value:
    - lo=0: {W[7:0], R[23:0]}
    - lo=1: {W[15:0], R[15:0]}
    - lo=2: {W[23:0], R[7:0]}
    - lo=3: W
  - LWR:
    - lo=0: W
    - lo=1: {R[31:24], W[31:8]}
    - lo=2: {R[31:16], W[31:16]}
    - lo=3: {R[31:8], W[31:24]}
  - NONE: the stored wdata.
- Hold state machine:
  - States: LIVE (hold_valid=0) and HELD (hold_valid=1).
  - LIVE → HELD when stall_wb=1 and the stored op is not NONE. hold_data is loaded with dmem_rdata on that edge.
  - HELD → LIVE on the first edge where stall_wb=0, or on flush or rst.
  - HELD → HELD otherwise; hold_data is not reloaded.
- Write enable:
  - wb_we = stored we AND (stored waddr ≠ 0).
  - wb_we stays asserted across WB stall cycles. Repeated writes are idempotent.

## Timing
- Reset values: wb_we=0, wb_waddr=0, wb_wdata=0, wb_is_load=0, hold_valid=0, hold_data=0.
- Latency: MEM inputs appear on the wb_* outputs exactly 1 cycle later.
- wb_wdata is combinational from the stage register, dmem_rdata and hold_data. No extra cycle.
- The register file bypasses same-cycle writes to its reads, so no extra forwarding is needed here.
- flush and stall_wb in the same cycle: flush wins. The stage becomes a bubble and the FSM returns to LIVE.
- stall_mem=1 and stall_wb=0: a bubble enters WB and the current WB instruction retires.
- rst asserted mid-stall: all state is cleared at the next edge.

## Structure
- Load-op codes and the `RegBus`/`RegAddrBus` widths go in the shared `define.v`.
- The extraction/merge logic goes in one combinational sub-module, `load_align`, with inputs op, lo, W and R and output data.
- The stage register and the hold FSM stay in the top module.

## Test plan
- ALU write: mem_we=1, waddr=5, wdata=0x12345678, op=NONE. Next cycle: wb_we=1, waddr=5, wdata=0x12345678.
- LB with lo=3 and dmem_rdata=0x80FF7F01. wdata=0xFFFFFF80; LBU gives 0x00000080. LH with lo=2 gives 0xFFFF80FF.
- LWL with lo=1, W=0xAABBCCDD, R=0x11223344 gives 0xCCDD3344. LWR with lo=1 gives 0x11AABBCC.
- LW enters WB, then stall_wb is held for 3 cycles while dmem_rdata changes from 0xDEADBEEF to 0x0. wdata stays 0xDEADBEEF throughout, and the next instruction is captured when the stall releases.
- waddr=0 with mem_we=1 gives wb_we=0. flush together with stall_wb gives a bubble next cycle (wb_we=0).
- rst pulsed during HELD: all outputs are 0 next cycle and hold_valid=0.
